// File: rtl/l1_event_addr_queue.sv
// L1 event address queue.
// Runs the circular-buffer write address, turns every L1A into a buffer
// address (write address at trigger time minus latency), delays it through a
// short pipeline and stores it in a show-ahead event FIFO for readout.
//
// Handshake: wrEn is a one-clock strobe with no back-pressure. A push that
// meets a full queue without a simultaneous pop is dropped and counted.
// rdEn pops the head at the edge where it is sampled, and only while
// empty==0. A pop on an empty queue is ignored.
module l1_event_addr_queue #(
    parameter int ADDRWIDTH = 7,
    parameter int QDEPTHLOG = 3,
    parameter int WRDELAY   = 2,
    parameter int AFTHRESH  = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [ADDRWIDTH-1:0] latency,
    input  logic                 wrEn,
    input  logic                 rdEn,
    output logic [ADDRWIDTH-1:0] wrAddr,
    output logic [ADDRWIDTH-1:0] rdAddr,
    output logic [QDEPTHLOG:0]   wordCount,
    output logic                 empty,
    output logic                 full,
    output logic                 almostFull,
    output logic                 firstEvent,
    output logic [7:0]           overflowCount
);

    localparam int                 DEPTH   = 1 << QDEPTHLOG;
    localparam logic [QDEPTHLOG:0] FULLCNT = DEPTH[QDEPTHLOG:0];
    localparam logic [QDEPTHLOG:0] AFCNT   = AFTHRESH[QDEPTHLOG:0];
    localparam logic [QDEPTHLOG:0] CNTONE  = (QDEPTHLOG+1)'(1);
    localparam logic [QDEPTHLOG-1:0] PTRONE = QDEPTHLOG'(1);

    // L1A pipeline: valid bits carry reset, tags are plain data.
    logic [WRDELAY-1:0]   pipeV;
    logic [ADDRWIDTH-1:0] pipeT [WRDELAY];

    // Event storage and pointers.
    logic [ADDRWIDTH-1:0] mem [DEPTH];
    logic [QDEPTHLOG-1:0] wrPtr;
    logic [QDEPTHLOG-1:0] rdPtr;

    logic                 pushReq;
    logic [ADDRWIDTH-1:0] pushTag;
    logic                 pop;
    logic                 accept;
    logic                 drop;
    logic [QDEPTHLOG:0]   nextCount;
    logic [ADDRWIDTH-1:0] nextRdAddr;

    // Write address counter, free running while enabled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wrAddr <= '0;
        end else if (enable) begin
            wrAddr <= wrAddr + ADDRWIDTH'(1);
        end
    end

    // Trigger valid pipeline; cleared by reset so pending L1As are lost.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pipeV <= '0;
        end else begin
            pipeV[0] <= wrEn;
            for (int i = 1; i < WRDELAY; i++) begin
                pipeV[i] <= pipeV[i-1];
            end
        end
    end

    // Tag pipeline: capture uses wrAddr before this edge's increment.
    always_ff @(posedge clk) begin
        pipeT[0] <= wrAddr - latency;
        for (int i = 1; i < WRDELAY; i++) begin
            pipeT[i] <= pipeT[i-1];
        end
    end

    // Push/pop decision and next-state values for the queue.
    always_comb begin
        pushReq    = pipeV[WRDELAY-1];
        pushTag    = pipeT[WRDELAY-1];
        pop        = rdEn && !empty;
        // At full a simultaneous pop frees the slot the push lands in.
        accept     = pushReq && (!full || pop);
        drop       = pushReq && full && !pop;
        nextCount  = wordCount;
        nextRdAddr = rdAddr;
        case ({accept, pop})
            2'b10:   nextCount = wordCount + CNTONE;
            2'b01:   nextCount = wordCount - CNTONE;
            default: nextCount = wordCount;
        endcase
        if (empty && accept) begin
            nextRdAddr = pushTag;
        end else if (pop) begin
            if (wordCount > CNTONE) begin
                nextRdAddr = mem[rdPtr + PTRONE];
            end else if (accept) begin
                nextRdAddr = pushTag;
            end
        end
    end

    // Queue storage write.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wrPtr] <= pushTag;
        end
    end

    // Queue pointers, occupancy, registered flags and head output.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            wordCount  <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            almostFull <= 1'b0;
            firstEvent <= 1'b0;
            rdAddr     <= '0;
        end else begin
            if (accept) wrPtr <= wrPtr + PTRONE;
            if (pop)    rdPtr <= rdPtr + PTRONE;
            wordCount  <= nextCount;
            empty      <= (nextCount == '0);
            full       <= (nextCount == FULLCNT);
            almostFull <= (nextCount >= AFCNT);
            firstEvent <= empty && accept;
            rdAddr     <= nextRdAddr;
        end
    end

    // Saturating count of L1As lost to a full queue.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflowCount <= '0;
        end else if (drop && (overflowCount != 8'hFF)) begin
            overflowCount <= overflowCount + 8'd1;
        end
    end

endmodule

// File: tb/tb_l1_event_addr_queue.sv
// Bench for l1_event_addr_queue: directed scenarios followed by random
// traffic, every cycle compared against a queue-based reference model.
module tb_l1_event_addr_queue;

    localparam int AW  = 7;
    localparam int QL  = 3;
    localparam int WD  = 2;
    localparam int AF  = 6;
    localparam int DEP = 1 << QL;
    localparam int AMOD = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [AW-1:0] latency;
    logic          wrEn;
    logic          rdEn;
    logic [AW-1:0] wrAddr;
    logic [AW-1:0] rdAddr;
    logic [QL:0]   wordCount;
    logic          empty;
    logic          full;
    logic          almostFull;
    logic          firstEvent;
    logic [7:0]    overflowCount;

    l1_event_addr_queue #(
        .ADDRWIDTH(AW), .QDEPTHLOG(QL), .WRDELAY(WD), .AFTHRESH(AF)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .latency(latency),
        .wrEn(wrEn), .rdEn(rdEn), .wrAddr(wrAddr), .rdAddr(rdAddr),
        .wordCount(wordCount), .empty(empty), .full(full),
        .almostFull(almostFull), .firstEvent(firstEvent),
        .overflowCount(overflowCount)
    );

    // Clock
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int mWr = 0;
    int mQ[$];
    int mOvf = 0;
    bit mFirst = 0;
    int pendTag[$];
    int pendDue[$];
    int edgeNo = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model of one posedge, using the inputs currently driven.
    task automatic modelEdge();
        bit wasEmpty;
        bit pushNow;
        int tag;
        edgeNo++;
        if (!reset) begin
            mWr = 0;
            mQ.delete();
            mOvf = 0;
            mFirst = 0;
            pendTag.delete();
            pendDue.delete();
        end else begin
            pushNow = 0;
            tag = 0;
            if (pendDue.size() > 0 && pendDue[0] == edgeNo) begin
                pushNow = 1;
                tag = pendTag.pop_front();
                void'(pendDue.pop_front());
            end
            wasEmpty = (mQ.size() == 0);
            if (rdEn && mQ.size() > 0) void'(mQ.pop_front());
            if (pushNow) begin
                if (mQ.size() < DEP) mQ.push_back(tag);
                else if (mOvf < 255) mOvf++;
            end
            mFirst = wasEmpty && (mQ.size() > 0);
            if (wrEn) begin
                pendTag.push_back(((mWr - int'(latency)) % AMOD + AMOD) % AMOD);
                pendDue.push_back(edgeNo + WD);
            end
            if (enable) mWr = (mWr + 1) % AMOD;
        end
    endtask

    task automatic checkAll();
        check("wrAddr", 32'(wrAddr), 32'(mWr));
        check("wordCount", 32'(wordCount), 32'(mQ.size()));
        check("empty", 32'(empty), 32'(mQ.size() == 0));
        check("full", 32'(full), 32'(mQ.size() == DEP));
        check("almostFull", 32'(almostFull), 32'(mQ.size() >= AF));
        check("firstEvent", 32'(firstEvent), 32'(mFirst));
        check("overflowCount", 32'(overflowCount), 32'(mOvf));
        if (mQ.size() > 0) check("rdAddr", 32'(rdAddr), 32'(mQ[0]));
    endtask

    // Driver: apply inputs, take one edge, update model, compare.
    task automatic step(input bit rst, input bit en, input bit we, input bit re);
        reset  = rst;
        enable = en;
        wrEn   = we;
        rdEn   = re;
        @(posedge clk);
        modelEdge();
        #1;
        checkAll();
    endtask

    initial begin
        int firstTag;
        int n;
        reset = 1'b0; enable = 1'b0; wrEn = 1'b0; rdEn = 1'b0; latency = 7'd10;

        // 1: reset with random other inputs
        for (int i = 0; i < 2; i++) begin
            latency = 7'($urandom_range(0, AMOD-1));
            step(0, 1'($urandom), 1'($urandom), 1'($urandom));
        end
        check("rst_rdAddr", 32'(rdAddr), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_ovf", 32'(overflowCount), 0);

        // 2: latency 10, trigger at wrAddr 5
        latency = 7'd10;
        n = 0;
        while (mWr != 5 && n < 200) begin step(1, 1, 0, 0); n++; end
        check("reach_wr5", 32'(wrAddr), 5);
        step(1, 1, 1, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        check("t2_rdAddr", 32'(rdAddr), 123);
        check("t2_first", 32'(firstEvent), 1);
        check("t2_count", 32'(wordCount), 1);
        step(1, 1, 0, 0);
        check("t2_first_drop", 32'(firstEvent), 0);

        // 3: pop the entry, then 9 triggers back to back
        step(1, 1, 0, 1);
        firstTag = ((mWr - 10) % AMOD + AMOD) % AMOD;
        for (int i = 0; i < 9; i++) step(1, 1, 1, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        check("t3_full", 32'(full), 1);
        check("t3_ovf", 32'(overflowCount), 1);
        check("t3_head", 32'(rdAddr), 32'(firstTag));

        // 4: push lands together with a pop while full
        step(1, 1, 1, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 1);
        check("t4_count", 32'(wordCount), 8);
        check("t4_ovf", 32'(overflowCount), 1);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 1);
        check("t4_drained", 32'(empty), 1);

        // 5: pops on empty while wrAddr wraps, then latency 3 at wrAddr 1
        n = 0;
        while (mWr != 0 && n < 200) begin step(1, 1, 0, 1); n++; end
        check("t5_wrap", 32'(wrAddr), 0);
        check("t5_empty", 32'(wordCount), 0);
        latency = 7'd3;
        step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        check("t5_tag", 32'(rdAddr), 126);

        // 6: trigger immediately followed by reset
        step(1, 1, 1, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0);
            check("t6_first", 32'(firstEvent), 0);
        end
        check("t6_empty", 32'(empty), 1);

        // Random traffic
        for (int i = 0; i < 700; i++) begin
            if (i % 100 == 0) latency = 7'($urandom_range(0, AMOD-1));
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 99) < 45),
                 ($urandom_range(0, 99) < 35));
        end
        // Long overflow burst to exercise saturation
        for (int i = 0; i < 280; i++) step(1, 1, 1, 0);
        check("sat_ovf", 32'(overflowCount), 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
